smu_seq_engine: RTL and testbench

Next-generation signal monitor unit: M independent sequence-detection channels watch a K-bit observable bus and raise per-channel trigger pulses when a programmed N-step pattern completes. Each step has its own masked compare, polarity, final-step flag and optional timeout window. Configuration arrives as a serial bitstream in the same clock domain, with no CDC stage. Once loaded, it stays locked until reset. The block sits beside the host logic it patches and drives the trigger inputs of the downstream control units.

---
 rtl/smu_seq_pkg.sv | 57 +++++
 rtl/smu_seq_channel.sv | 91 +++++++++
 rtl/smu_seq_engine.sv | 67 ++++++
 tb/tb_smu_seq_engine.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/smu_seq_pkg.sv
// Shared entry layout, sizing helpers and entry decode for smu_seq_engine.
// Build option SMU_SEQ_TIMEOUT_EN adds a per-step Timeout field to every entry.
package smu_seq_pkg;
`ifdef SMU_SEQ_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam int MAX_K       = 32;
    localparam int MAX_TO_W    = 32;
    localparam int MAX_ENTRY_W = 2 * MAX_K + 2 + MAX_TO_W;

    localparam int FINAL_OFF = 0;
    localparam int NEG_OFF   = 1;
    localparam int MASK_OFF  = 2;

    // Fields are sized for the widest supported build; decode zero-fills the rest.
    typedef struct packed {
        logic [MAX_TO_W-1:0] timeout;
        logic [MAX_K-1:0]    cmp_val;
        logic [MAX_K-1:0]    cmp_mask;
        logic                cmp_neg;
        logic                final_step;
    } entry_t;

    function automatic int val_off(input int k);
        return k + 2;
    endfunction

    function automatic int to_off(input int k);
        return 2 * k + 2;
    endfunction

    function automatic int entry_w(input int k, input int to_w);
        return 2 * k + 2 + (TIMEOUT_EN ? to_w : 0);
    endfunction

    function automatic int cfg_size(input int n, input int m, input int k, input int to_w);
        return n * m * entry_w(k, to_w);
    endfunction

    function automatic entry_t unpack_entry(input logic [MAX_ENTRY_W-1:0] raw,
                                            input int k, input int to_w);
        entry_t           e;
        logic [MAX_K-1:0]    km;
        logic [MAX_TO_W-1:0] tm;
        km           = MAX_K'((64'd1 << k) - 64'd1);
        tm           = MAX_TO_W'((64'd1 << to_w) - 64'd1);
        e.final_step = raw[FINAL_OFF];
        e.cmp_neg    = raw[NEG_OFF];
        e.cmp_mask   = MAX_K'(raw >> MASK_OFF) & km;
        e.cmp_val    = MAX_K'(raw >> val_off(k)) & km;
        e.timeout    = TIMEOUT_EN ? (MAX_TO_W'(raw >> to_off(k)) & tm) : '0;
        return e;
    endfunction
endpackage

// File: rtl/smu_seq_channel.sv
// One sequence-detection channel: step register, masked compare, trigger pipe.
// With SMU_SEQ_TIMEOUT_EN a saturating counter can send a stalled step back to 0.
module smu_seq_channel
    import smu_seq_pkg::*;
#(
    parameter int N    = 4,
    parameter int K    = 8,
    parameter int TO_W = 8,
    parameter int EW   = entry_w(K, TO_W)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [K-1:0]         p,
    input  logic [EW-1:0]        entry,
    output logic [$clog2(N)-1:0] step,
    output logic                 trigger
);
    localparam int SW = $clog2(N);

    logic [MAX_ENTRY_W-1:0] raw;
    entry_t                 e;
    logic                   match;
    logic                   last;
    logic                   expire;
    logic                   done_nx;
    logic                   trig_p0;
    logic [SW-1:0]          step_nx;
    logic                   unused_fields;

    always_comb begin
        raw           = '0;
        raw[EW-1:0]   = entry;
        e             = unpack_entry(raw, K, TO_W);
        match         = ((((p ^ e.cmp_val[K-1:0]) & e.cmp_mask[K-1:0]) == '0) ^ e.cmp_neg);
        last          = e.final_step || (step == SW'(N - 1));
        unused_fields = ^{e.timeout, e.cmp_val, e.cmp_mask};
    end

`ifdef SMU_SEQ_TIMEOUT_EN
    logic [TO_W-1:0] cnt;
    logic [TO_W-1:0] cnt_inc;
    logic [TO_W-1:0] limit;

    always_comb begin
        limit   = e.timeout[TO_W-1:0];
        cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
        expire  = en && !match && (step != '0) && (limit != '0) && (cnt_inc == limit);
    end

    // Cleared on every step entry (match or expiry) and whenever idle in step 0.
    always_ff @(posedge clk) begin
        if (rst || !en || match || expire || step == '0)
            cnt <= '0;
        else
            cnt <= cnt_inc;
    end
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        step_nx = step;
        done_nx = 1'b0;
        if (en) begin
            if (match) begin
                if (last) begin
                    step_nx = '0;
                    done_nx = 1'b1;
                end else begin
                    step_nx = step + 1'b1;
                end
            end else if (expire) begin
                step_nx = '0;
            end
        end
    end

    // p0: completion captured at the matching edge; p1: trigger pulse out.
    always_ff @(posedge clk) begin
        if (rst) begin
            step    <= '0;
            trig_p0 <= 1'b0;
            trigger <= 1'b0;
        end else begin
            step    <= step_nx;
            trig_p0 <= done_nx;
            trigger <= trig_p0;
        end
    end
endmodule

// File: rtl/smu_seq_engine.sv
// Signal monitor top: serial config deserializer with lock, M sequence channels.
// Entry layout depends on SMU_SEQ_TIMEOUT_EN (see smu_seq_pkg).
module smu_seq_engine
    import smu_seq_pkg::*;
#(
    parameter int N    = 4,
    parameter int K    = 8,
    parameter int M    = 4,
    parameter int TO_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [K-1:0]           p,
    input  logic                   cfg_in,
    input  logic                   cfg_valid,
    output logic                   cfg_done,
    output logic [M-1:0]           trigger,
    output logic [M*$clog2(N)-1:0] smu_state
);
    localparam int SW = $clog2(N);
    localparam int EW = entry_w(K, TO_W);
    localparam int CS = cfg_size(N, M, K, TO_W);
    localparam int CW = $clog2(CS + 1);

    logic [CS-1:0] cfg_sr;
    logic [CW-1:0] bit_cnt;

    // First bit sent ends up at bit 0 once the full stream is shifted in.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_sr   <= '0;
            bit_cnt  <= '0;
            cfg_done <= 1'b0;
        end else if (cfg_valid && !cfg_done) begin
            cfg_sr  <= {cfg_in, cfg_sr[CS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == CW'(CS - 1))
                cfg_done <= 1'b1;
        end
    end

    for (genvar m = 0; m < M; m++) begin : g_ch
        logic [EW-1:0] tbl [N];
        logic [SW-1:0] step;

        for (genvar n = 0; n < N; n++) begin : g_step
            assign tbl[n] = cfg_sr[(n * M + m) * EW +: EW];
        end

        smu_seq_channel #(
            .N    (N),
            .K    (K),
            .TO_W (TO_W),
            .EW   (EW)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (cfg_done),
            .p       (p),
            .entry   (tbl[step]),
            .step    (step),
            .trigger (trigger[m])
        );

        assign smu_state[m*SW +: SW] = step;
    end
endmodule

// File: tb/tb_smu_seq_engine.sv
// Self-checking bench for smu_seq_engine: directed scenarios plus random p,
// all cycles compared against a bit-array/step-counter reference model.
module tb_smu_seq_engine;
    localparam int N    = 4;
    localparam int K    = 8;
    localparam int M    = 4;
    localparam int TO_W = 8;
    localparam int SW   = 2;
`ifdef SMU_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
    localparam int EW    = 2 * K + 2 + TO_W;
`else
    localparam bit TO_EN = 1'b0;
    localparam int EW    = 2 * K + 2;
`endif
    localparam int CS = N * M * EW;

    logic            clk = 1'b0;
    logic            rst;
    logic [K-1:0]    p;
    logic            cfg_in;
    logic            cfg_valid;
    logic            cfg_done;
    logic [M-1:0]    trigger;
    logic [M*SW-1:0] smu_state;

    always #5 clk = ~clk;

    smu_seq_engine #(.N(N), .K(K), .M(M), .TO_W(TO_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .p         (p),
        .cfg_in    (cfg_in),
        .cfg_valid (cfg_valid),
        .cfg_done  (cfg_done),
        .trigger   (trigger),
        .smu_state (smu_state)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: configuration kept as an indexed bit image.
    bit cfg_img [CS];
    bit m_bits  [CS];
    int m_cnt;
    bit m_done;
    int m_step [M];
    int m_tmr  [M];
    bit m_comp [M];
    bit m_trig [M];

    function automatic int fld(int n, int m, int off, int w);
        int v = 0;
        for (int i = 0; i < w; i++)
            v |= int'(m_bits[(n * M + m) * EW + off + i]) << i;
        return v;
    endfunction

    task automatic model_edge();
        if (rst) begin
            foreach (m_bits[i]) m_bits[i] = 1'b0;
            m_cnt  = 0;
            m_done = 1'b0;
            for (int m = 0; m < M; m++) begin
                m_step[m] = 0; m_tmr[m] = 0; m_comp[m] = 1'b0; m_trig[m] = 1'b0;
            end
            return;
        end
        for (int m = 0; m < M; m++) begin
            int  s, val, msk, to;
            bit  hit;
            m_trig[m] = m_comp[m];
            m_comp[m] = 1'b0;
            if (m_done) begin
                s   = m_step[m];
                val = fld(s, m, K + 2, K);
                msk = fld(s, m, 2, K);
                hit = (((int'(p) ^ val) & msk) == 0) != (fld(s, m, 1, 1) == 1);
                if (hit) begin
                    m_tmr[m] = 0;
                    if (fld(s, m, 0, 1) == 1 || s == N - 1) begin
                        m_step[m] = 0;
                        m_comp[m] = 1'b1;
                    end else begin
                        m_step[m] = s + 1;
                    end
                end else if (TO_EN && s > 0) begin
                    to = fld(s, m, 2 * K + 2, TO_W);
                    if (m_tmr[m] < (1 << TO_W) - 1) m_tmr[m]++;
                    if (to != 0 && m_tmr[m] == to) begin
                        m_step[m] = 0;
                        m_tmr[m]  = 0;
                    end
                end
            end
        end
        if (cfg_valid && !m_done) begin
            m_bits[m_cnt] = cfg_in;
            m_cnt++;
            if (m_cnt == CS) m_done = 1'b1;
        end
    endtask

    task automatic cyc();
        logic [63:0] ex;
        model_edge();
        @(posedge clk);
        #1;
        ex = '0;
        ex[M*SW+M] = m_done;
        for (int m = 0; m < M; m++) begin
            ex[M*SW+m]    = m_trig[m];
            ex[m*SW +: SW] = SW'(m_step[m]);
        end
        check("outs", 64'({cfg_done, trigger, smu_state}), ex);
    endtask

    function automatic int st(int m);
        return int'(smu_state[m*SW +: SW]);
    endfunction

    task automatic send(input bit b);
        if ($urandom_range(0, 7) == 0) begin
            cfg_valid = 1'b0;
            cfg_in    = 1'($urandom);
            cyc();
        end
        cfg_valid = 1'b1;
        cfg_in    = b;
        cyc();
        cfg_valid = 1'b0;
    endtask

    task automatic put(int n, int m, int val, int msk, bit neg, bit fin, int to);
        int b = (n * M + m) * EW;
        cfg_img[b]     = fin;
        cfg_img[b + 1] = neg;
        for (int i = 0; i < K; i++) begin
            cfg_img[b + 2 + i]     = msk[i];
            cfg_img[b + K + 2 + i] = val[i];
        end
        if (TO_EN)
            for (int i = 0; i < TO_W; i++) cfg_img[b + 2 * K + 2 + i] = to[i];
    endtask

    task automatic hold(input logic [K-1:0] v, input int cycles);
        p = v;
        for (int i = 0; i < cycles; i++) cyc();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        int picks [13] = '{8'hA5, 8'h31, 8'h3C, 8'h11, 8'h22, 8'h33, 8'h44,
                           8'hF0, 8'h0F, 8'h5A, 8'h01, 8'h00, 0};
        int guard;

        rst = 1'b1; p = '0; cfg_in = 1'b0; cfg_valid = 1'b0;
        repeat (3) cyc();
        check("rst_cfg_done", cfg_done, 0);
        check("rst_trigger", trigger, 0);
        check("rst_state", smu_state, 0);
        rst = 1'b0;

        // Partial stream, then reset: the partial load must be discarded.
        for (int i = 0; i < 200; i++) send(1'($urandom));
        check("partial_done", cfg_done, 0);
        rst = 1'b1; cyc(); rst = 1'b0;
        check("partial_rst_done", cfg_done, 0);

        put(0, 0, 8'hA5, 8'hFF, 0, 0, 0); put(1, 0, 8'h3C, 8'hF0, 0, 1, 0);
        put(0, 1, 8'h11, 8'hFF, 0, 0, 0); put(1, 1, 8'h22, 8'hFF, 0, 0, 3);
        put(2, 1, 8'h33, 8'hFF, 0, 0, 0); put(3, 1, 8'h44, 8'hFF, 0, 0, 0);
        for (int n = 0; n < N; n++) put(n, 2, 8'h00, 8'h01, 1, 0, 0);
        put(0, 3, 8'hF0, 8'hF0, 0, 0, 0); put(1, 3, 8'h0F, 8'h0F, 0, 0, 5);
        put(2, 3, 8'h80, 8'h80, 1, 0, 0); put(3, 3, 8'h5A, 8'hFF, 0, 1, 0);

        for (int i = 0; i < CS - 1; i++) send(cfg_img[i]);
        check("done_early", cfg_done, 0);
        send(cfg_img[CS-1]);
        check("done_set", cfg_done, 1);
        for (int i = 0; i < 20; i++) send(1'($urandom));
        check("done_locked", cfg_done, 1);

        // Channel 2: negated compare on bit 0, completes through step N-1.
        hold(8'h01, 3);
        check("ch2_step3", st(2), 3);
        check("ch2_no_early", trigger, 0);
        hold(8'h01, 1);
        check("ch2_wrap", st(2), 0);
        hold(8'h00, 1);
        check("ch2_trig", trigger, 4'b0100);
        check("ch2_others_idle", smu_state, 0);
        hold(8'h00, 1);
        check("ch2_trig_once", trigger, 0);

        // Channel 0: final flag on step 1, two edges to trigger.
        hold(8'hA5, 1);
        check("ch0_s1", st(0), 1);
        hold(8'h31, 1);
        check("ch0_s0", st(0), 0);
        check("ch0_trig_wait", trigger[0], 0);
        hold(8'h00, 1);
        check("ch0_trig", trigger[0], 1);
        hold(8'h00, 1);
        check("ch0_trig_once", trigger[0], 0);

        // Channel 1: step 1 timeout, then a match on the expiry cycle.
        hold(8'h11, 1);
        check("ch1_s1", st(1), 1);
        if (TO_EN) begin
            hold(8'h00, 2);
            check("ch1_wait", st(1), 1);
            hold(8'h00, 1);
            check("ch1_expired", st(1), 0);
            check("ch1_no_trig", trigger[1], 0);
            hold(8'h11, 1);
            hold(8'h00, 2);
            hold(8'h22, 1);
            check("ch1_match_wins", st(1), 2);
        end else begin
            hold(8'h00, 10);
            check("ch1_waits", st(1), 1);
            hold(8'h22, 1);
            check("ch1_s2", st(1), 2);
        end
        hold(8'h33, 1);
        hold(8'h44, 1);
        check("ch1_done", st(1), 0);
        hold(8'h00, 1);
        check("ch1_trig", trigger[1], 1);

        // Channel 0 with a long gap between matches.
        hold(8'hA5, 1);
        hold(8'h00, 100);
        check("gap_s1", st(0), 1);
        hold(8'h31, 1);
        hold(8'h00, 1);
        check("gap_trig", trigger[0], 1);

        for (int i = 0; i < 600; i++) begin
            int k = $urandom_range(0, 12);
            p = (k == 12) ? K'($urandom) : K'(picks[k]);
            cyc();
        end

        // Reset while a trigger is pending: nothing may come out.
        p = 8'h01;
        guard = 0;
        do begin cyc(); guard++; end while (!m_comp[2] && guard < 8);
        check("pend_reached", m_comp[2], 1);
        rst = 1'b1; cyc(); rst = 1'b0;
        check("midseq_state", smu_state, 0);
        check("midseq_trig", trigger, 0);
        check("midseq_done", cfg_done, 0);
        cyc();
        check("midseq_trig_after", trigger, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
